// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-segment display controller.
//
// Scans DIGITS digits over a shared segment/dp bus, one digit per slot of 2**SLOT_W cycles.
// Each slot starts with BLANK_CYC cycles with every digit deselected (anti-ghosting).
// A 4-bit PWM then lights the digit while the top four slot-counter bits are <= brightness_i.
// New values enter a shadow buffer via valid/ready. They are committed to the displayed
// buffer only at a frame boundary, so no frame ever shows a mix of old and new nibbles.
//
// Optional feature: define SEG7_SCAN_LZ_BLANK_EN for leading-zero blanking. With it, digit
// i > 0 shows no segments when nibbles i..DIGITS-1 are all zero.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   load_valid_i   new display value offered
//   load_ready_o   shadow buffer free (no commit pending)
//   load_data_i    hex nibbles, nibble i drives digit i (digit 0 least significant)
//   load_dp_i      decimal point per digit
//   brightness_i   PWM level 0..15, sampled every cycle
//   seg_o          segments {a,b,c,d,e,f,g}, active-high, registered
//   dp_o           decimal point, active-high, registered
//   digit_sel_n_o  digit selects, active-low, at most one low, registered
//   frame_start_o  one-cycle pulse with the first registered output of the digit 0 slot
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned SLOT_W    = 7,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [4*DIGITS-1:0]   load_data_i,
  input  logic [DIGITS-1:0]     load_dp_i,
  input  logic [3:0]            brightness_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     digit_sel_n_o,
  output logic                  frame_start_o
);

  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DataW = 4 * DIGITS;

  typedef enum logic [1:0] {PhBlank, PhOn, PhOff} phase_e;

  // Segment pattern for one hex nibble, {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    pat = 7'b0000000;
    unique case (nib)
      4'h0: pat = 7'b1111110;
      4'h1: pat = 7'b0110000;
      4'h2: pat = 7'b1101101;
      4'h3: pat = 7'b1111001;
      4'h4: pat = 7'b0110011;
      4'h5: pat = 7'b1011011;
      4'h6: pat = 7'b1011111;
      4'h7: pat = 7'b1110000;
      4'h8: pat = 7'b1111111;
      4'h9: pat = 7'b1111011;
      4'hA: pat = 7'b1110111;
      4'hB: pat = 7'b0011111;
      4'hC: pat = 7'b1001110;
      4'hD: pat = 7'b0111101;
      4'hE: pat = 7'b1001111;
      4'hF: pat = 7'b1000111;
    endcase
    return pat;
  endfunction

  // Scan counters
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]   digit_idx_q, digit_idx_d;
  // Set by the first frame boundary after reset; suppresses frame_start for the first frame.
  logic              started_q, started_d;

  // Display buffers
  logic [DataW-1:0]  active_data_q, active_data_d;
  logic [DIGITS-1:0] active_dp_q, active_dp_d;
  logic [DataW-1:0]  shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic              pending_q, pending_d;

  // Registered outputs
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] sel_n_q, sel_n_d;
  logic              frame_start_q, frame_start_d;

  logic   slot_wrap, boundary, accept, commit;
  phase_e phase;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       lz_blank;

  // Counters, handshake and commit
  always_comb begin
    slot_wrap   = (slot_cnt_q == {SLOT_W{1'b1}});
    boundary    = slot_wrap && (digit_idx_q == IdxW'(DIGITS - 1));
    accept      = load_valid_i && !pending_q;
    // Commit looks at the pending flag from before this cycle's accept.
    commit      = boundary && pending_q;

    slot_cnt_d  = slot_cnt_q + SLOT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_wrap) begin
      digit_idx_d = boundary ? '0 : digit_idx_q + IdxW'(1);
    end
    started_d = started_q | boundary;

    shadow_data_d = accept ? load_data_i : shadow_data_q;
    shadow_dp_d   = accept ? load_dp_i   : shadow_dp_q;
    active_data_d = commit ? shadow_data_q : active_data_q;
    active_dp_d   = commit ? shadow_dp_q   : active_dp_q;

    pending_d = pending_q;
    if (commit) pending_d = 1'b0;
    if (accept) pending_d = 1'b1;
  end

  // Phase, digit data and next registered outputs
  always_comb begin
    phase = PhOff;
    if (slot_cnt_q < SLOT_W'(BLANK_CYC)) begin
      phase = PhBlank;
    end else if (slot_cnt_q[SLOT_W-1 -: 4] <= brightness_i) begin
      phase = PhOn;
    end

    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_idx_q == IdxW'(i)) begin
        cur_nib = active_data_q[4*i +: 4];
        cur_dp  = active_dp_q[i];
      end
    end

    lz_blank = 1'b0;
`ifdef SEG7_SCAN_LZ_BLANK_EN
    begin
      logic all_zero;
      all_zero = 1'b1;
      // Walk down from the top digit, accumulating "everything from here up is zero".
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        all_zero = all_zero && (active_data_q[4*i +: 4] == 4'h0);
        if ((digit_idx_q == IdxW'(i)) && all_zero) lz_blank = 1'b1;
      end
    end
`endif

    seg_d   = 7'b0000000;
    dp_d    = 1'b0;
    sel_n_d = {DIGITS{1'b1}};
    if (phase == PhOn) begin
      sel_n_d = ~(DIGITS'(1) << digit_idx_q);
      seg_d   = lz_blank ? 7'b0000000 : hex7(cur_nib);
      dp_d    = cur_dp;
    end

    frame_start_d = started_q && (slot_cnt_q == '0) && (digit_idx_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      started_q     <= 1'b0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      sel_n_q       <= {DIGITS{1'b1}};
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      started_q     <= started_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      sel_n_q       <= sel_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready_o  = !pending_q;
  assign seg_o         = seg_q;
  assign dp_o          = dp_q;
  assign digit_sel_n_o = sel_n_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl. A driver issues loads, brightness changes and resets. Each accepted
// load is queued together with the frame boundary at which it must become visible. A monitor
// samples on the falling edge, pops queue entries as their frames begin, and compares every
// registered output against a model built from slot/frame arithmetic.
module tb_seg7_scan_ctrl;

  localparam int DIGITS    = 2;
  localparam int SLOT_W    = 7;
  localparam int BLANK_CYC = 4;
  localparam int LEN       = 1 << SLOT_W;
  localparam int FRAME     = DIGITS * LEN;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111,
    7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101,
    7'b1001111, 7'b1000111};

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                load_valid = 1'b0;
  logic                load_ready;
  logic [4*DIGITS-1:0] load_data = '0;
  logic [DIGITS-1:0]   load_dp = '0;
  logic [3:0]          brightness = 4'hF;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   digit_sel_n;
  logic                frame_start;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dpv;
    int                  ka;  // cycle of acceptance
    int                  b;   // boundary cycle at which it commits
  } ent_t;

  ent_t sb_q[$];

  seg7_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SLOT_W    (SLOT_W),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .load_valid_i  (load_valid),
    .load_ready_o  (load_ready),
    .load_data_i   (load_data),
    .load_dp_i     (load_dp),
    .brightness_i  (brightness),
    .seg_o         (seg),
    .dp_o          (dp),
    .digit_sel_n_o (digit_sel_n),
    .frame_start_o (frame_start)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; cycle 0 is the first cycle with reset low.
  int k;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, k, got, exp);
    end
  endtask

  // Not ready while some accepted value is still waiting for its boundary.
  function automatic bit model_ready(input int kk);
    foreach (sb_q[i]) begin
      if (sb_q[i].ka < kk && kk <= sb_q[i].b) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected {frame_start, dp, digit_sel_n, seg} registered from cycle p.
  function automatic logic [DIGITS+8:0] expect_out(input int p, input logic [4*DIGITS-1:0] data,
                                                   input logic [DIGITS-1:0] dpv,
                                                   input logic [3:0] bri);
    int s;
    int d;
    logic fs;
    logic [6:0] sg;
    logic [DIGITS-1:0] sel;
    s  = p % LEN;
    d  = (p / LEN) % DIGITS;
    fs = ((p % FRAME) == 0) && (p >= FRAME);
    if (s >= BLANK_CYC && s < (int'(bri) + 1) * LEN / 16) begin
      sg = HEX_TAB[data[4*d +: 4]];
`ifdef SEG7_SCAN_LZ_BLANK_EN
      if (d > 0 && (data >> (4 * d)) == 0) sg = 7'b0000000;
`endif
      sel    = {DIGITS{1'b1}};
      sel[d] = 1'b0;
      return {fs, dpv[d], sel, sg};
    end
    return {fs, 1'b0, {DIGITS{1'b1}}, 7'b0000000};
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [4*DIGITS-1:0] shown_data, prev_data;
    logic [DIGITS-1:0]   shown_dp, prev_dp;
    logic [3:0]          prev_bri;
    logic [DIGITS+8:0]   exp_v;
    shown_data = '0; shown_dp = '0; prev_data = '0; prev_dp = '0; prev_bri = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        shown_data = '0;
        shown_dp   = '0;
        continue;
      end
      while (sb_q.size() > 0 && sb_q[0].b + 1 == k) begin
        shown_data = sb_q[0].data;
        shown_dp   = sb_q[0].dpv;
        sb_q.pop_front();
      end
      if (k == 0) exp_v = {1'b0, 1'b0, {DIGITS{1'b1}}, 7'b0000000};
      else        exp_v = expect_out(k - 1, prev_data, prev_dp, prev_bri);
      check("outputs{fs,dp,sel_n,seg}", {frame_start, dp, digit_sel_n, seg}, exp_v);
      check("load_ready", load_ready, model_ready(k));
      prev_data = shown_data;
      prev_dp   = shown_dp;
      prev_bri  = brightness;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit jitter);
    for (int i = 0; i < n; i++) begin
      if (jitter && $urandom_range(0, 31) == 0) brightness = 4'($urandom_range(0, 15));
      step();
    end
  endtask

  // Offer a value, hold it until the model says it is taken, then drop valid.
  task automatic send(input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] p);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = p;
    while (!model_ready(k) && n <= FRAME + 4) begin
      step();
      n++;
    end
    if (n > FRAME + 4) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: value %h not taken within %0d cycles", d, FRAME + 4);
    end else begin
      sb_q.push_back('{data: d, dpv: p, ka: k, b: ((k + 1) / FRAME + 1) * FRAME - 1});
    end
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_pos(input int modulus, input int target);
    int n;
    n = 0;
    while ((k % modulus) != target && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // First slot after reset: 5 blank output cycles, then digit 0 showing "0".
    for (int j = 0; j <= 5; j++) begin
      if (j == 0) check("ready_after_reset", load_ready, 1'b1);
      if (j < 5) begin
        check("blank_sel_n", digit_sel_n, 2'b11);
      end else begin
        check("first_lit_sel_n", digit_sel_n, 2'b10);
        check("first_lit_seg", seg, 7'b1111110);
      end
      step();
    end
    idle(2 * FRAME, 1'b0);

    send(8'h3A, 2'b01);
    idle(2 * FRAME + 2, 1'b0);

    // Back-to-back with valid held.
    send(8'h12, 2'b00);
    send(8'h34, 2'b10);
    idle(2 * FRAME + 2, 1'b0);

    brightness = 4'd7;
    idle(FRAME, 1'b0);
    brightness = 4'd0;
    idle(FRAME, 1'b0);
    brightness = 4'd15;

    send(8'h05, 2'b00);
    idle(2 * FRAME + 2, 1'b0);

    // Accept exactly on a boundary cycle while idle: must wait a full extra frame.
    wait_pos(FRAME, FRAME - 1);
    send(8'hC7, 2'b11);
    idle(2 * FRAME + 2, 1'b0);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 2) == 0) brightness = 4'($urandom_range(0, 15));
      send(8'($urandom), 2'($urandom));
      idle(int'($urandom_range(0, FRAME + 40)), 1'b1);
    end
    idle(FRAME + 2, 1'b1);

    // Asynchronous reset mid-slot with a load pending.
    brightness = 4'd15;
    wait_pos(FRAME, 10);
    send(8'h99, 2'b11);
    wait_pos(FRAME, 60);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sel_n", digit_sel_n, 2'b11);
    check("async_rst_seg", seg, 7'b0000000);
    check("async_rst_dp", dp, 1'b0);
    check("async_rst_ready", load_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2 * FRAME + 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
